// File: rtl/hazard_mc_pkg.sv
// Shared constants for the hazard unit: forward-select encodings and the PC register index.
package hazard_mc_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // The PC is the highest architectural register index.
  function automatic logic [31:0] pcIndex(input int regW);
    return 32'((1 << regW) - 1);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding select: Memory stage beats Writeback, the PC is never forwarded.
import hazard_mc_pkg::*;

module hazard_fwd_sel #(
  parameter int REG_W = 4
) (
  input  logic [REG_W-1:0] raE,
  input  logic [REG_W-1:0] waM,
  input  logic [REG_W-1:0] waW,
  input  logic             regWriteM,
  input  logic             regWriteW,
  output logic [1:0]       fwdSel
);

  localparam logic [REG_W-1:0] PC_IDX = REG_W'(pcIndex(REG_W));

  always_comb begin
    fwdSel = FWD_RF;
    if (raE != PC_IDX) begin
      if (regWriteM && (waM == raE)) begin
        fwdSel = FWD_MEM;
      end else if (regWriteW && (waW == raE)) begin
        fwdSel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_mc.sv
// Pipeline hazard unit with internal forwarding compares, multi-cycle multiply stalls
// and a saturating stall-cycle counter.
import hazard_mc_pkg::*;

module hazard_mc #(
  parameter int REG_W   = 4,
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] RA1D,
  input  logic [REG_W-1:0] RA2D,
  input  logic [REG_W-1:0] RA1E,
  input  logic [REG_W-1:0] RA2E,
  input  logic [REG_W-1:0] RA3E,
  input  logic [REG_W-1:0] WA3E,
  input  logic [REG_W-1:0] WA3M,
  input  logic [REG_W-1:0] WA3W,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MulStartE,
  input  logic             BranchTakenD,
  input  logic             PCWrPendingF,
  input  logic             PCSrcW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [1:0]       ForwardCE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             MulBusy,
  output logic [CNT_W-1:0] StallCount
);

  localparam bit         MULTI   = (MUL_LAT > 1);
  localparam logic [3:0] MC_LOAD = 4'(MUL_LAT - 1);

  logic [3:0]       mcReg;
  logic [REG_W-1:0] raE [3];
  logic [1:0]       fwdSel [3];
  logic             ldStall;
  logic             mulIssue;
  logic             pcWr;
  logic             branch;
  logic             pcSrc;

  assign raE[0] = RA1E;
  assign raE[1] = RA2E;
  assign raE[2] = RA3E;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : gFwd
      hazard_fwd_sel #(.REG_W(REG_W)) uFwdSel (
        .raE       (raE[gi]),
        .waM       (WA3M),
        .waW       (WA3W),
        .regWriteM (RegWriteM),
        .regWriteW (RegWriteW),
        .fwdSel    (fwdSel[gi])
      );
    end
  endgenerate

  assign ForwardAE = reset ? fwdSel[0] : FWD_RF;
  assign ForwardBE = reset ? fwdSel[1] : FWD_RF;
  assign ForwardCE = reset ? fwdSel[2] : FWD_RF;

  // Every control source is gated by reset so all controls read 0 while it is held low.
  assign ldStall  = reset & MemtoRegE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D));
  assign mulIssue = reset & MULTI & MulStartE & (mcReg == 4'd0);
  assign pcWr     = reset & PCWrPendingF;
  assign branch   = reset & BranchTakenD;
  assign pcSrc    = reset & PCSrcW;

  assign MulBusy = (mcReg != 4'd0) | mulIssue;
  assign StallE  = MulBusy;
  assign StallD  = ldStall | MulBusy;
  assign StallF  = ldStall | MulBusy | pcWr;
  assign FlushM  = MulBusy;
  assign FlushE  = (ldStall & ~MulBusy) | branch;
  assign FlushD  = pcWr | pcSrc | branch;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcReg      <= 4'd0;
      StallCount <= '0;
    end else begin
      if (mcReg != 4'd0) begin
        mcReg <= mcReg - 4'd1;
      end else if (mulIssue) begin
        mcReg <= MC_LOAD;
      end
      if (StallF && (StallCount != {CNT_W{1'b1}})) begin
        StallCount <= StallCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_mc.sv
// Self-checking bench for hazard_mc: directed scenarios plus randomized cycles against a
// behavioural model tracking remaining multiply cycles and a clamped stall total.
module tb_hazard_mc;

  localparam int REG_W   = 4;
  localparam int MUL_LAT = 3;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [REG_W-1:0] RA1D, RA2D, RA1E, RA2E, RA3E, WA3E, WA3M, WA3W;
  logic             RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MulStartE;
  logic             BranchTakenD, PCWrPendingF, PCSrcW;
  logic [1:0]       ForwardAE, ForwardBE, ForwardCE;
  logic             StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy;
  logic [CNT_W-1:0] StallCount;

  logic [6:0] ctlObs;
  logic [5:0] fwdObs;
  assign ctlObs = {StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy};
  assign fwdObs = {ForwardAE, ForwardBE, ForwardCE};

  int passCount  = 0;
  int totalCount = 0;
  int busyLeft   = 0;
  int cntModel   = 0;

  hazard_mc #(.REG_W(REG_W), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E), .RA3E(RA3E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MulStartE(MulStartE), .BranchTakenD(BranchTakenD),
    .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardCE(ForwardCE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .MulBusy(MulBusy), .StallCount(StallCount)
  );

  // Reference forwarding rule for one Execute operand.
  function automatic logic [1:0] expFwd(input logic [REG_W-1:0] ra);
    if (int'(ra) == (1 << REG_W) - 1) return 2'b00;
    if (RegWriteM && WA3M == ra) return 2'b10;
    if (RegWriteW && WA3W == ra) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [5:0] expFwdAll();
    return {expFwd(RA1E), expFwd(RA2E), expFwd(RA3E)};
  endfunction

  // Reference controls {StallF,StallD,StallE,FlushD,FlushE,FlushM,MulBusy} for current inputs.
  function automatic logic [6:0] expCtl();
    bit ld, busy;
    if (!reset) return 7'b0;
    ld   = MemtoRegE && RegWriteE && (WA3E == RA1D || WA3E == RA2D);
    busy = (busyLeft > 0) || (MulStartE && MUL_LAT > 1);
    return {ld || busy || PCWrPendingF, ld || busy, busy,
            PCWrPendingF || PCSrcW || BranchTakenD, (ld && !busy) || BranchTakenD, busy, busy};
  endfunction

  task automatic advance();
    logic [6:0] e;
    @(posedge clk);
    e = expCtl();
    if (reset) begin
      if (e[6] && cntModel < CNT_MAX) cntModel++;
      if (busyLeft > 0) busyLeft--;
      else if (MulStartE && MUL_LAT > 1) busyLeft = MUL_LAT - 1;
    end
    #1;
  endtask

  task automatic clearInputs();
    {RA1D, RA2D, RA1E, RA2E, RA3E, WA3E, WA3M, WA3W} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MulStartE} = '0;
    {BranchTakenD, PCWrPendingF, PCSrcW} = '0;
  endtask

  function automatic logic [REG_W-1:0] randIdx();
    if ($urandom_range(0, 4) == 0) return '1;
    return REG_W'($urandom_range(0, 3));
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    clearInputs();
    MulStartE = 1; PCWrPendingF = 1; BranchTakenD = 1; PCSrcW = 1;
    MemtoRegE = 1; RegWriteE = 1; WA3E = 5; RA1D = 5;
    RA1E = 3; WA3M = 3; RegWriteM = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      totalCount++;
      if (ctlObs !== 7'b0) $display("FAIL reset_ctl cycle %0d: got %b want 0000000", i, ctlObs);
      else passCount++;
      totalCount++;
      if (fwdObs !== 6'b0) $display("FAIL reset_fwd cycle %0d: got %b want 000000", i, fwdObs);
      else passCount++;
      totalCount++;
      if (StallCount !== '0) $display("FAIL reset_count cycle %0d: got %0d want 0", i, StallCount);
      else passCount++;
      advance();
    end
    clearInputs();
    @(negedge clk);
    reset = 1'b1;
    busyLeft = 0;
    cntModel = 0;
    advance();
    $display("test_reset done");
  endtask

  task automatic test_forward();
    clearInputs();
    RA1E = 3; WA3M = 3; RegWriteM = 1; WA3W = 3; RegWriteW = 1; RA2E = 7; RA3E = 3;
    @(negedge clk);
    totalCount++;
    if (ForwardAE !== 2'b10) $display("FAIL fwd_m_priority: got %b want 10", ForwardAE);
    else passCount++;
    totalCount++;
    if (fwdObs !== expFwdAll()) $display("FAIL fwd_all_m: got %b want %b", fwdObs, expFwdAll());
    else passCount++;
    advance();
    RegWriteM = 0;
    @(negedge clk);
    totalCount++;
    if (ForwardAE !== 2'b01) $display("FAIL fwd_w: got %b want 01", ForwardAE);
    else passCount++;
    advance();
    RegWriteM = 1; RA1E = 15; WA3M = 15; WA3W = 15;
    @(negedge clk);
    totalCount++;
    if (ForwardAE !== 2'b00) $display("FAIL fwd_pc: got %b want 00", ForwardAE);
    else passCount++;
    totalCount++;
    if (fwdObs !== expFwdAll()) $display("FAIL fwd_all_pc: got %b want %b", fwdObs, expFwdAll());
    else passCount++;
    advance();
    $display("test_forward done");
  endtask

  task automatic test_load();
    clearInputs();
    MemtoRegE = 1; RegWriteE = 1; WA3E = 5; RA2D = 5;
    @(negedge clk);
    totalCount++;
    if ({StallF, StallD, FlushE, MulBusy} !== 4'b1110)
      $display("FAIL load_stall: got %b want 1110", {StallF, StallD, FlushE, MulBusy});
    else passCount++;
    totalCount++;
    if (StallCount !== CNT_W'(0)) $display("FAIL load_count_before: got %0d want 0", StallCount);
    else passCount++;
    advance();
    clearInputs();
    @(negedge clk);
    totalCount++;
    if (StallCount !== CNT_W'(1) || StallF !== 1'b0)
      $display("FAIL load_count_after: got count %0d stallF %b want 1 0", StallCount, StallF);
    else passCount++;
    advance();
    $display("test_load done");
  endtask

  task automatic test_mul();
    clearInputs();
    MulStartE = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      totalCount++;
      if ({MulBusy, StallE, FlushM} !== {3{i < MUL_LAT}})
        $display("FAIL mul_busy cycle %0d: got %b want %b", i, {MulBusy, StallE, FlushM}, {3{i < MUL_LAT}});
      else passCount++;
      totalCount++;
      if (ctlObs !== expCtl()) $display("FAIL mul_ctl cycle %0d: got %b want %b", i, ctlObs, expCtl());
      else passCount++;
      advance();
      MulStartE = 0;
    end
    @(negedge clk);
    totalCount++;
    if (int'(StallCount) !== cntModel) $display("FAIL mul_count: got %0d want %0d", StallCount, cntModel);
    else passCount++;
    $display("test_mul done");
  endtask

  task automatic test_branch_mul();
    clearInputs();
    MulStartE = 1;
    advance();
    MulStartE = 0; BranchTakenD = 1;
    @(negedge clk);
    totalCount++;
    if ({FlushD, StallE, FlushE, MulBusy} !== 4'b1111)
      $display("FAIL branch_in_mul: got %b want 1111", {FlushD, StallE, FlushE, MulBusy});
    else passCount++;
    advance();
    BranchTakenD = 0; MemtoRegE = 1; RegWriteE = 1; WA3E = 2; RA1D = 2;
    @(negedge clk);
    totalCount++;
    if ({MulBusy, StallD, FlushE} !== 3'b110)
      $display("FAIL load_in_mul: got %b want 110", {MulBusy, StallD, FlushE});
    else passCount++;
    advance();
    clearInputs();
    @(negedge clk);
    totalCount++;
    if (MulBusy !== 1'b0) $display("FAIL mul_end: got %b want 0", MulBusy);
    else passCount++;
    advance();
    $display("test_branch_mul done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      RA1D = randIdx(); RA2D = randIdx(); RA1E = randIdx(); RA2E = randIdx(); RA3E = randIdx();
      WA3E = randIdx(); WA3M = randIdx(); WA3W = randIdx();
      RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      MemtoRegE = 1'($urandom);
      MulStartE = ($urandom_range(0, 3) == 0);
      BranchTakenD = ($urandom_range(0, 5) == 0);
      PCWrPendingF = ($urandom_range(0, 5) == 0);
      PCSrcW = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      $display("rand %0d: ctl=%b fwd=%b cnt=%0d", i, ctlObs, fwdObs, StallCount);
      totalCount++;
      if (ctlObs !== expCtl()) $display("FAIL rand_ctl %0d: got %b want %b", i, ctlObs, expCtl());
      else passCount++;
      totalCount++;
      if (fwdObs !== expFwdAll()) $display("FAIL rand_fwd %0d: got %b want %b", i, fwdObs, expFwdAll());
      else passCount++;
      totalCount++;
      if (int'(StallCount) !== cntModel) $display("FAIL rand_count %0d: got %0d want %0d", i, StallCount, cntModel);
      else passCount++;
      advance();
    end
    $display("test_random done");
  endtask

  task automatic test_reset_mid();
    clearInputs();
    MulStartE = 1;
    advance();
    MulStartE = 0;
    #1;
    totalCount++;
    if (MulBusy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", MulBusy);
    else passCount++;
    #1;
    reset = 1'b0;
    #1;
    busyLeft = 0;
    cntModel = 0;
    totalCount++;
    if (MulBusy !== 1'b0 || StallCount !== '0)
      $display("FAIL mid_reset_async: got busy %b count %0d want 0 0", MulBusy, StallCount);
    else passCount++;
    @(negedge clk);
    reset = 1'b1;
    advance();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      totalCount++;
      if (ctlObs !== 7'b0) $display("FAIL mid_after_release %0d: got %b want 0000000", i, ctlObs);
      else passCount++;
      advance();
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_saturate();
    clearInputs();
    PCWrPendingF = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      totalCount++;
      if (int'(StallCount) !== cntModel) $display("FAIL sat_count %0d: got %0d want %0d", i, StallCount, cntModel);
      else passCount++;
      advance();
    end
    @(negedge clk);
    totalCount++;
    if (StallCount !== CNT_W'(CNT_MAX)) $display("FAIL sat_hold: got %0d want %0d", StallCount, CNT_MAX);
    else passCount++;
    clearInputs();
    $display("test_saturate done");
  endtask

  initial begin
    clearInputs();
    reset = 1'b0;
    test_reset();
    test_forward();
    test_load();
    test_mul();
    test_branch_mul();
    test_random();
    test_reset_mid();
    test_saturate();
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/hazard_mc.md
Name: hazard_mc

Overview:
Parametrised successor to the pipeline's hazard unit. It takes raw register addresses instead of precomputed match bits, so forwarding compares happen internally for any register-file size. It also adds a multi-cycle execute mode (iterative multiply) with an internal busy counter and stall/bubble control, plus a saturating stall-cycle counter. It sits beside controller and datapath in the pipelined core top and drives all forward/stall/flush controls.

Parameters:
REG_W, 4, register index width (2**REG_W architectural registers; the PC is index 2**REG_W-1)
MUL_LAT, 3, cycles a multiply occupies Execute (legal range 1..15; 1 = single-cycle, no busy stall)
CNT_W, 16, width of the stall-cycle performance counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
RA1D, RA2D  in  REG_W  source registers of the Decode instruction
RA1E, RA2E, RA3E  in  REG_W  source registers of the Execute instruction (RA3E = shift/accumulate operand)
WA3E, WA3M, WA3W  in  REG_W  destination registers in E/M/W
RegWriteE, RegWriteM, RegWriteW  in  1  destination write enables
MemtoRegE  in  1  Execute instruction is a load
MulStartE  in  1  Execute instruction is a multi-cycle multiply
BranchTakenD  in  1  branch resolved taken in Decode
PCWrPendingF  in  1  PC-writing instruction in D/E/M
PCSrcW  in  1  PC write retiring in Writeback
ForwardAE, ForwardBE, ForwardCE  out  2  00 = register file, 01 = ResultW, 10 = ALUOutM
StallF, StallD, StallE  out  1  hold the F/D/E pipeline registers
FlushD, FlushE, FlushM  out  1  insert a bubble into D/E/M
MulBusy  out  1  multi-cycle operation in progress
StallCount  out  CNT_W  number of cycles with StallF=1, saturating

Behaviour:
- Forwarding is combinational, per operand X in {1,2,3}, in priority order:
  - 10 if RegWriteM and WA3M==RAXE
  - else 01 if RegWriteW and WA3W==RAXE
  - else 00
  - The PC index (all ones) is never forwarded and always gives 00.
- Load-use hazard: LdStall = MemtoRegE & RegWriteE & (WA3E==RA1D | WA3E==RA2D).
- Multiply busy counter mc (4 bits):
  - Reset value 0.
  - If mc==0 and MulStartE and MUL_LAT>1, load MUL_LAT-1.
  - Else if mc!=0, decrement by 1.
  - MulBusy = (mc!=0) | (MulStartE & mc==0 & MUL_LAT>1).
  - MulStartE is ignored while mc!=0, because E is held.
- Stall and flush equations:
  - StallE = MulBusy
  - StallD = LdStall | MulBusy
  - StallF = LdStall | MulBusy | PCWrPendingF
  - FlushM = MulBusy
  - FlushE = (LdStall & ~MulBusy) | BranchTakenD
  - FlushD = PCWrPendingF | PCSrcW | BranchTakenD
- Simultaneous events:
  - BranchTakenD while MulBusy: FlushE is still asserted, but StallE wins and the E register holds; FlushD also asserts.
  - LdStall while MulBusy: only the MulBusy controls act (E is held, no FlushE).
- Total multiply occupancy of E is exactly MUL_LAT cycles: the issue cycle plus MUL_LAT-1 busy cycles.
- StallCount:
  - Reset value 0.
  - Increments by 1 on each cycle with StallF=1.
  - Holds at 2**CNT_W-1 once it reaches that value.
- Reset (reset=0) is asynchronous:
  - mc and StallCount clear immediately.
  - While reset is low, all stall/flush/busy outputs are forced to 0 and Forward* to 00.
  - Reset during a busy multiply abandons it; after release, mc==0.
- No other state is held; the block has zero latency from inputs to outputs except through mc and StallCount.

Decomposition:
- Shared package: forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, and the PC index constant derived from REG_W.
- One natural sub-module, hazard_fwd_sel: a combinational per-operand priority compare, instantiated three times.
- The busy counter and the performance counter stay inline.

Test Plan:
- RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 -> ForwardAE=10 (M beats W); drop RegWriteM -> 01; RA1E=15 with both matching -> 00.
- Load: MemtoRegE=1, RegWriteE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1 for one cycle; StallCount goes 0->1.
- MUL_LAT=3, one-cycle MulStartE pulse -> MulBusy/StallE/FlushM high for 3 consecutive cycles (mc 0->2->1->0), then low.
- Branch during multiply: BranchTakenD=1 in the busy cycle when mc=2 -> FlushD=1, StallE=1, FlushE=1, E register held; mc continues to 1.
- Reset mid-operation: assert reset low asynchronously while mc=2 -> MulBusy=0 and StallCount=0 immediately; after release with no MulStartE, all stalls stay 0.
- CNT_W=4, hold PCWrPendingF=1 for 20 cycles -> StallCount saturates at 15 and holds.
